// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the two requesters and the register-file write-port arbiter.
// The arbiter sits on the slave side; the requesters and register file sit on the master side.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        starve_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  we, waddr, wdata, starve_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output we, waddr, wdata, starve_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single write-port arbiter for the register file: port 0 (pipeline) has fixed priority,
// port 1 (long-latency unit) is force-granted after STARVE_MAX consecutive denied cycles.
module regfile_wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 i_rdy,
  regfile_wb_arbiter_if.slave bus
);
  logic              w_force1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_starve_cnt;

  assign w_force1 = (r_starve_cnt >= 4'(STARVE_MAX));

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst && i_rdy) begin
      if (w_force1 && bus.req1_valid) begin
        w_gnt1 = 1'b1;
      end else if (bus.req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_addr = w_gnt1 ? bus.req1_addr : bus.req0_addr;
  assign w_data = w_gnt1 ? bus.req1_data : bus.req0_data;

  // x0 writes are consumed but never raise we; waddr/wdata hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_starve_cnt <= '0;
    end else if (i_rdy) begin
      if (w_gnt0 || w_gnt1) begin
        r_we    <= (w_addr != '0);
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end else begin
        r_we <= 1'b0;
      end
      if (w_gnt1 || !bus.req1_valid) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != 4'hF) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.we         = r_we;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  assign bus.starve_cnt = r_starve_cnt;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of grants, output register and register-file contents.
module tb_regfile_wb_arbiter;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_i;
  logic rdy_i;
  logic v0, v1;
  logic [ADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] d0, d1;

  int n_vec = 0;
  int n_err = 0;

  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  int                m_starve;
  logic [DATA_W-1:0] m_rf   [32];
  logic [DATA_W-1:0] dut_rf [32];
  int                dut_wcnt [32];

  regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst  (rst_i),
    .i_rdy(rdy_i),
    .bus  (bus)
  );

  assign bus.req0_valid = v0;
  assign bus.req0_addr  = a0;
  assign bus.req0_data  = d0;
  assign bus.req1_valid = v1;
  assign bus.req1_addr  = a1;
  assign bus.req1_data  = d1;

  always #5 clk = ~clk;

  // -1: no grant, 0/1: granted port
  function automatic int exp_grant();
    if (!(rst_i && rdy_i)) return -1;
    if (m_starve >= STARVE_MAX && v1) return 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Advance one clock: record what the DUT commits, advance the model, sample #1 after the edge.
  task automatic tick();
    int g;
    g = exp_grant();
    if (rst_i && rdy_i && bus.we === 1'b1) begin
      dut_rf[int'(bus.waddr)] = bus.wdata;
      dut_wcnt[int'(bus.waddr)]++;
    end
    if (!rst_i) begin
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_starve = 0;
    end else if (rdy_i) begin
      if (m_we) m_rf[int'(m_waddr)] = m_wdata;
      if (g == 0) begin
        m_we = (a0 != 0); m_waddr = a0; m_wdata = d0;
      end else if (g == 1) begin
        m_we = (a1 != 0); m_waddr = a1; m_wdata = d1;
      end else begin
        m_we = 1'b0;
      end
      if (g == 1 || !v1) m_starve = 0;
      else if (m_starve < 15) m_starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; rdy_i = 1'b1;
    v0 = 1'b1; a0 = 5'd1; d0 = 32'h1111_1111;
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h2222_2222;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_ready cycle %0d: got r0=%b r1=%b, want 0 0", c, bus.req0_ready, bus.req1_ready);
      end
      tick();
    end
    rst_i = 1'b1; v0 = 1'b0; v1 = 1'b0;
    n_vec++;
    if (bus.we !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0 || bus.starve_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: got we=%b waddr=%0d wdata=%h starve=%0d, want all 0",
               bus.we, bus.waddr, bus.wdata, bus.starve_cnt);
    end
  endtask

  task automatic test_single();
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEAD_BEEF; v1 = 1'b0;
    #1;
    n_vec++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++; $display("FAIL single0_ready: got %b, want 1", bus.req0_ready);
    end
    tick();
    v0 = 1'b0;
    n_vec++;
    if (bus.we !== 1'b1 || bus.waddr !== 5'd5 || bus.wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single0_write: got we=%b waddr=%0d wdata=%h, want 1 5 deadbeef", bus.we, bus.waddr, bus.wdata);
    end
    tick();
    n_vec++;
    if (bus.we !== 1'b0) begin
      n_err++; $display("FAIL single0_idle: got we=%b, want 0", bus.we);
    end
    v1 = 1'b1; a1 = 5'd9; d1 = 32'h1234_5678;
    #1;
    n_vec++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_err++; $display("FAIL single1_ready: got r0=%b r1=%b, want 0 1", bus.req0_ready, bus.req1_ready);
    end
    tick();
    v1 = 1'b0;
    n_vec++;
    if (bus.we !== 1'b1 || bus.waddr !== 5'd9 || bus.wdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL single1_write: got we=%b waddr=%0d wdata=%h, want 1 9 12345678", bus.we, bus.waddr, bus.wdata);
    end
    tick();
    n_vec++;
    if (bus.we !== 1'b0) begin
      n_err++; $display("FAIL single1_idle: got we=%b, want 0", bus.we);
    end
  endtask

  task automatic test_starvation();
    logic e0, e1;
    int   es;
    a1 = 5'd7; d1 = $urandom;
    for (int c = 0; c < 5; c++) begin
      v0 = 1'b1; a0 = 5'($urandom_range(1, 31)); d0 = $urandom;
      v1 = (c <= 3);
      e0 = (c != 3);
      e1 = (c == 3);
      es = (c == 4) ? 0 : c;
      #1;
      n_vec++;
      if (bus.req0_ready !== e0 || bus.req1_ready !== e1 || bus.starve_cnt !== 4'(es)) begin
        n_err++;
        $display("FAIL starve cycle %0d: got r0=%b r1=%b cnt=%0d, want %b %b %0d",
                 c, bus.req0_ready, bus.req1_ready, bus.starve_cnt, e0, e1, es);
      end
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    tick();
  endtask

  task automatic test_x0_drop();
    logic [DATA_W-1:0] d;
    v0 = 1'b1; a0 = 5'd0; d0 = 32'hFFFF_FFFF; v1 = 1'b0;
    #1;
    n_vec++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++; $display("FAIL x0_ready: got %b, want 1", bus.req0_ready);
    end
    tick();
    v0 = 1'b0;
    d = $urandom;
    v1 = 1'b1; a1 = 5'd3; d1 = d;
    #1;
    n_vec++;
    if (bus.we !== 1'b0 || bus.req1_ready !== 1'b1) begin
      n_err++; $display("FAIL x0_nowrite: got we=%b r1=%b, want 0 1", bus.we, bus.req1_ready);
    end
    tick();
    v1 = 1'b0;
    n_vec++;
    if (bus.we !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== d) begin
      n_err++;
      $display("FAIL x0_next: got we=%b waddr=%0d wdata=%h, want 1 3 %h", bus.we, bus.waddr, bus.wdata, d);
    end
    tick();
  endtask

  task automatic test_rdy_stall();
    logic [DATA_W-1:0] d;
    int base;
    d = $urandom;
    v0 = 1'b1; a0 = 5'd4; d0 = d; v1 = 1'b0;
    tick();
    base = dut_wcnt[4];
    rdy_i = 1'b0;
    v0 = 1'b1; a0 = 5'd6; v1 = 1'b1; a1 = 5'd8;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (bus.we !== 1'b1 || bus.waddr !== 5'd4 || bus.wdata !== d || bus.req0_ready !== 1'b0 ||
          bus.req1_ready !== 1'b0 || bus.starve_cnt !== 4'd0) begin
        n_err++;
        $display("FAIL stall cycle %0d: got we=%b waddr=%0d wdata=%h r0=%b r1=%b cnt=%0d, want 1 4 %h 0 0 0",
                 c, bus.we, bus.waddr, bus.wdata, bus.req0_ready, bus.req1_ready, bus.starve_cnt, d);
      end
      tick();
    end
    rdy_i = 1'b1; v0 = 1'b0; v1 = 1'b0;
    tick();
    n_vec++;
    if (dut_wcnt[4] - base !== 1 || bus.we !== 1'b0) begin
      n_err++;
      $display("FAIL stall_commit: got commits=%0d we=%b, want 1 0", dut_wcnt[4] - base, bus.we);
    end
  endtask

  task automatic test_same_addr_race();
    v0 = 1'b1; a0 = 5'd10; d0 = 32'hA;
    v1 = 1'b1; a1 = 5'd10; d1 = 32'hB;
    #1;
    n_vec++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL race_first: got r0=%b r1=%b, want 1 0", bus.req0_ready, bus.req1_ready);
    end
    tick();
    v0 = 1'b0;
    #1;
    n_vec++;
    if (bus.req1_ready !== 1'b1 || bus.we !== 1'b1 || bus.wdata !== 32'hA) begin
      n_err++;
      $display("FAIL race_a: got r1=%b we=%b wdata=%h, want 1 1 a", bus.req1_ready, bus.we, bus.wdata);
    end
    tick();
    v1 = 1'b0;
    n_vec++;
    if (bus.we !== 1'b1 || bus.waddr !== 5'd10 || bus.wdata !== 32'hB) begin
      n_err++;
      $display("FAIL race_b: got we=%b waddr=%0d wdata=%h, want 1 10 b", bus.we, bus.waddr, bus.wdata);
    end
    tick();
    n_vec++;
    if (dut_rf[10] !== 32'hB) begin
      n_err++; $display("FAIL race_final: got r10=%h, want b", dut_rf[10]);
    end
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 400; c++) begin
      rst_i = ($urandom_range(0, 63) != 0);
      rdy_i = ($urandom_range(0, 7) != 0);
      if (!v0 && $urandom_range(0, 3) != 0) begin
        v0 = 1'b1; a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1'b1; a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
      end
      #1;
      g = exp_grant();
      n_vec++;
      if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1) || bus.we !== m_we ||
          bus.waddr !== m_waddr || bus.wdata !== m_wdata || bus.starve_cnt !== 4'(m_starve)) begin
        n_err++;
        $display("FAIL random cycle %0d: got r0=%b r1=%b we=%b waddr=%0d wdata=%h cnt=%0d, want %b %b %b %0d %h %0d",
                 c, bus.req0_ready, bus.req1_ready, bus.we, bus.waddr, bus.wdata, bus.starve_cnt,
                 (g == 0), (g == 1), m_we, m_waddr, m_wdata, m_starve);
      end
      tick();
      if (g == 0) v0 = 1'b0;
      if (g == 1) v1 = 1'b0;
    end
    rst_i = 1'b1; rdy_i = 1'b1; v0 = 1'b0; v1 = 1'b0;
    tick();
    tick();
    for (int r = 0; r < 32; r++) begin
      n_vec++;
      if (dut_rf[r] !== m_rf[r]) begin
        n_err++; $display("FAIL random_rf x%0d: got %h, want %h", r, dut_rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    rst_i = 1'b0; rdy_i = 1'b1;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_starve = 0;
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0; dut_rf[r] = '0; dut_wcnt[r] = 0;
    end
    test_reset();
    test_single();
    test_starvation();
    test_x0_drop();
    test_rdy_stall();
    test_same_addr_race();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the CPU register file, which has a single write port. It takes two writeback requesters over valid/ready handshakes: port 0 is the in-order pipeline writeback and port 1 is the long-latency unit (divider / late load return). It grants one request per cycle and drives a registered `we`/`waddr`/`wdata` onto the register file write port. Port 0 has fixed priority, and a bounded starvation counter guarantees port 1 forward progress.

## Interface
Parameters:
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.
- `STARVE_MAX`, 3: number of consecutive denied cycles of port 1 after which port 1 is force-granted; legal range 1..15.

Ports (reset rst, synchronous, active-low; clock clk):
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `rdy`, input, 1: global run enable; while 0 the block is frozen.
- `req0_valid`, input, 1: pipeline writeback request.
- `req0_addr`, input, ADDR_W: destination register of port 0.
- `req0_data`, input, DATA_W: write data of port 0.
- `req0_ready`, output, 1: port 0 accepted this cycle (combinational).
- `req1_valid`, input, 1: long-latency unit request.
- `req1_addr`, input, ADDR_W: destination register of port 1.
- `req1_data`, input, DATA_W: write data of port 1.
- `req1_ready`, output, 1: port 1 accepted this cycle (combinational).
- `we`, output, 1: register file write enable (registered).
- `waddr`, output, ADDR_W: register file write address (registered).
- `wdata`, output, DATA_W: register file write data (registered).
- `starve_cnt`, output, 4: current starvation count, for debug and coverage.

## Operation
- **Force flag.** `force1 = (starve_cnt >= STARVE_MAX)`.
- **Grant rule** (combinational, only when `rst`=1 and `rdy`=1):
  - `force1`=1 and `req1_valid`: grant port 1.
  - Otherwise `req0_valid`: grant port 0.
  - Otherwise `req1_valid`: grant port 1.
  - Otherwise: no grant.
- **Ready outputs.** `reqN_ready` = grant to N. At most one ready is high per cycle. Ready never depends on the same-cycle ready of the other port.
- **Transfer.** A transfer occurs on port N when `reqN_valid` and `reqN_ready` are both high at a rising edge. Requesters hold addr/data stable while valid and not ready.
- **Output stage** (on a rising edge with `rst`=1 and `rdy`=1):
  - On a transfer: `we` <= (addr != 0); `waddr` <= granted addr; `wdata` <= granted data.
  - A request to x0 is accepted and consumed but never written.
  - With no transfer: `we` <= 0; `waddr` and `wdata` hold.
- **Starvation counter** (updated on edges with `rdy`=1):
  - `req1_valid`=1 and port 1 not granted: increment, saturating at 15.
  - Port 1 granted: clear to 0.
  - `req1_valid`=0: clear to 0.
- **Write ordering.**
  - Same address on both ports in the same cycle: the granted one is written first. The loser is written in a later cycle, so the loser's value is final.
  - Correct program order between the two ports is the issuing logic's responsibility, not this block's.

## Timing
- **Reset** (`rst`=0 at an edge): `we`=0, `waddr`=0, `wdata`=0, `starve_cnt`=0. While `rst`=0, `req0_ready`=`req1_ready`=0.
- **Reset mid-operation.** A pending `we`=1 that has not yet been written is discarded. A request presented during reset is not accepted.
- **Latency.** Accept at edge N puts `we`/`waddr`/`wdata` valid after edge N. The register file commits the write at edge N+1. Throughput is 1 write per cycle.
- **`rdy`=0.**
  - Both readies are 0.
  - `we`, `waddr`, `wdata` and `starve_cnt` hold their values.
  - A `we`=1 presented when `rdy` fell stays asserted and commits at the first edge with `rdy`=1. No write is lost or duplicated, because the register file ignores writes while `rdy`=0.
- **Forced grant.** While port 0 streams continuously and port 1 waits, port 1 is granted no later than cycle STARVE_MAX+1 after it first asserts valid. Port 0 is stalled exactly that one cycle.

## Test plan
- **Reset.** Drive `rst`=0 for 2 cycles with both ports valid -> both readies stay 0. After release: `we`=0, `waddr`=0, `wdata`=0, `starve_cnt`=0.
- **Single writes.**
  - Port 0 only: addr 5, data 0xDEADBEEF -> `req0_ready`=1 that cycle; next cycle `we`=1, `waddr`=5, `wdata`=0xDEADBEEF; the cycle after, `we`=0.
  - Port 1 only: addr 9, data 0x12345678 -> same sequence on port 1.
- **Starvation** (STARVE_MAX=3). Port 0 valid every cycle, port 1 valid from cycle 0 with addr 7 -> port 0 granted at cycles 0, 1, 2; port 1 granted at cycle 3 (`starve_cnt`=3); port 0 resumes at cycle 4 with `starve_cnt`=0.
- **x0 drop.** Port 0 addr 0, data 0xFFFFFFFF -> `req0_ready`=1 and `we` stays 0. A back-to-back port 1 addr 3 request is then written normally.
- **`rdy` stall.** Accept port 0 addr 4, then pull `rdy`=0 for 3 cycles -> `we`=1, `waddr`=4 held, both readies 0, `starve_cnt` frozen. On the `rdy` rise the write commits exactly once.
- **Same-address race.** Both ports valid, addr 10, data 0xA (port 0) and 0xB (port 1) -> writes are 0xA then 0xB on consecutive cycles, so register 10 ends at 0xB.
